// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo constants: reservation-station tags, "no value" markers and
// default widths used by the CDB arbiter and its consumers.
package tomasulo_pkg;

   localparam int unsigned TAG_W_DEF  = 3;
   localparam int unsigned DATA_W_DEF = 16;

   typedef enum logic [TAG_W_DEF-1:0] {
      FREE_REGISTER    = 3'd0,
      RES_STATION_ADD1 = 3'd1,
      RES_STATION_ADD2 = 3'd2
   } rs_tag_e;

   localparam logic [DATA_W_DEF-1:0] Vj_Vk_sem_valor = 16'hFFF0;
   localparam logic [TAG_W_DEF-1:0]  Qj_Qk_sem_valor = 3'd0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority picker: first set request at or above rr_ptr,
// wrapping at N_REQ-1, wins.
module rr_arbiter #(
   parameter int unsigned N_REQ = 2,
   localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
)(
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] rr_ptr,
   output logic [N_REQ-1:0] grant,
   output logic [PTR_W-1:0] grant_idx,
   output logic             any_grant
);

   int unsigned      cand;
   logic [PTR_W-1:0] cand_idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      cand      = 0;
      cand_idx  = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         // explicit wrap keeps non-power-of-2 N_REQ correct
         cand = 32'(rr_ptr) + k;
         if (cand >= N_REQ) cand = cand - N_REQ;
         cand_idx = PTR_W'(cand);
         if (!any_grant && req[cand_idx]) begin
            any_grant       = 1'b1;
            grant[cand_idx] = 1'b1;
            grant_idx       = cand_idx;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one holding slot per requester, round-robin grant,
// one registered single-cycle broadcast of {tag, data} per grant.
module cdb_arbiter
   import tomasulo_pkg::*;
#(
   parameter int unsigned       N_REQ     = 2,
   parameter int unsigned       TAG_W     = TAG_W_DEF,
   parameter int unsigned       DATA_W    = DATA_W_DEF,
   parameter logic [DATA_W-1:0] IDLE_DATA = DATA_W'(Vj_Vk_sem_valor)
)(
   input  logic                      Clock,
   input  logic                      Reset,
   input  logic [N_REQ-1:0]          Req_valid,
   input  logic [N_REQ*TAG_W-1:0]    Req_tag,
   input  logic [N_REQ*DATA_W-1:0]   Req_data,
   output logic [N_REQ-1:0]          Req_ready,
   output logic                      CDB_valid,
   output logic [TAG_W-1:0]          Qi_CDB,
   output logic [DATA_W-1:0]         Qi_CDB_data,
   output logic [N_REQ-1:0]          CDB_grant,
   output logic                      Err_tag0
);

   localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]  slot_full;
   logic [TAG_W-1:0]  slot_tag  [N_REQ];
   logic [DATA_W-1:0] slot_data [N_REQ];
   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  win_idx;
   logic [N_REQ-1:0]  win_grant;
   logic              win_any;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
      .req       (slot_full),
      .rr_ptr    (rr_ptr),
      .grant     (win_grant),
      .grant_idx (win_idx),
      .any_grant (win_any)
   );

   // ready is the inverse of a flop, so there is no input-to-ready path
   assign Req_ready = ~slot_full;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         slot_full   <= '0;
         rr_ptr      <= '0;
         CDB_valid   <= 1'b0;
         Qi_CDB      <= TAG_W'(Qj_Qk_sem_valor);
         Qi_CDB_data <= IDLE_DATA;
         CDB_grant   <= '0;
         Err_tag0    <= 1'b0;
         for (int unsigned i = 0; i < N_REQ; i++) begin
            slot_tag[i]  <= '0;
            slot_data[i] <= '0;
         end
      end else begin
         // a slot is never granted and accepted on the same edge: grant needs full, accept needs empty
         for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win_grant[i]) slot_full[i] <= 1'b0;
            if (Req_valid[i] && !slot_full[i]) begin
               if (Req_tag[i*TAG_W +: TAG_W] == TAG_W'(FREE_REGISTER)) begin
                  Err_tag0 <= 1'b1;
               end else begin
                  slot_full[i] <= 1'b1;
                  slot_tag[i]  <= Req_tag[i*TAG_W +: TAG_W];
                  slot_data[i] <= Req_data[i*DATA_W +: DATA_W];
               end
            end
         end

         if (win_any) begin
            CDB_valid   <= 1'b1;
            Qi_CDB      <= slot_tag[win_idx];
            Qi_CDB_data <= slot_data[win_idx];
            CDB_grant   <= win_grant;
            if (win_idx == PTR_W'(N_REQ - 1)) rr_ptr <= '0;
            else                              rr_ptr <= win_idx + 1'b1;
         end else begin
            CDB_valid   <= 1'b0;
            Qi_CDB      <= TAG_W'(Qj_Qk_sem_valor);
            Qi_CDB_data <= IDLE_DATA;
            CDB_grant   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter; each cycle's CDB and ready state is compared
// as one packed {valid, tag, data, grant, ready} vector.
module tb_cdb_arbiter;
   import tomasulo_pkg::*;

   localparam int unsigned N  = 2;
   localparam int unsigned TW = 3;
   localparam int unsigned DW = 16;

   logic            Clock = 1'b0;
   logic            Reset = 1'b1;
   logic [N-1:0]    Req_valid = '0;
   logic [N*TW-1:0] Req_tag   = '0;
   logic [N*DW-1:0] Req_data  = '0;
   logic [N-1:0]    Req_ready;
   logic            CDB_valid;
   logic [TW-1:0]   Qi_CDB;
   logic [DW-1:0]   Qi_CDB_data;
   logic [N-1:0]    CDB_grant;
   logic            Err_tag0;

   int errors = 0;
   int checks = 0;
   logic [23:0] obs;
   logic [23:0] exp_v;

   always #5 Clock = ~Clock;

   cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW), .IDLE_DATA(16'hFFF0)) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .Req_valid   (Req_valid),
      .Req_tag     (Req_tag),
      .Req_data    (Req_data),
      .Req_ready   (Req_ready),
      .CDB_valid   (CDB_valid),
      .Qi_CDB      (Qi_CDB),
      .Qi_CDB_data (Qi_CDB_data),
      .CDB_grant   (CDB_grant),
      .Err_tag0    (Err_tag0)
   );

   assign obs = {CDB_valid, Qi_CDB, Qi_CDB_data, CDB_grant, Req_ready};

   task automatic tick;
      @(posedge Clock);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d);
      Req_valid[i]        = v;
      Req_tag[i*TW +: TW] = t;
      Req_data[i*DW +: DW] = d;
   endtask

   task automatic do_reset;
      Reset     = 1'b1;
      Req_valid = '0;
      tick();
      Reset = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      exp_v = {1'b0, 3'd0, 16'hFFF0, 2'b00, 2'b11};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL reset_state: got %h exp %h", obs, exp_v); end
      checks++;
      if (Err_tag0 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", Err_tag0); end
   endtask

   task automatic test_single;
      do_reset();
      set_req(0, 1'b1, RES_STATION_ADD1, 16'h0005);
      tick();
      Req_valid = '0;
      exp_v = {1'b0, 3'd0, 16'hFFF0, 2'b00, 2'b10};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL single_accept: got %h exp %h", obs, exp_v); end
      tick();
      exp_v = {1'b1, 3'd1, 16'h0005, 2'b01, 2'b11};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL single_bcast: got %h exp %h", obs, exp_v); end
      tick();
      exp_v = {1'b0, 3'd0, 16'hFFF0, 2'b00, 2'b11};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL single_idle: got %h exp %h", obs, exp_v); end
   endtask

   task automatic test_collision;
      do_reset();
      set_req(0, 1'b1, RES_STATION_ADD1, 16'h000A);
      set_req(1, 1'b1, RES_STATION_ADD2, 16'h000B);
      tick();
      Req_valid = '0;
      exp_v = {1'b0, 3'd0, 16'hFFF0, 2'b00, 2'b00};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL coll_accept: got %h exp %h", obs, exp_v); end
      tick();
      exp_v = {1'b1, 3'd1, 16'h000A, 2'b01, 2'b01};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL coll_first: got %h exp %h", obs, exp_v); end
      tick();
      exp_v = {1'b1, 3'd2, 16'h000B, 2'b10, 2'b11};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL coll_second: got %h exp %h", obs, exp_v); end
      tick();
      exp_v = {1'b0, 3'd0, 16'hFFF0, 2'b00, 2'b11};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL coll_idle: got %h exp %h", obs, exp_v); end
   endtask

   // each requester re-offers whenever ready; its n-th offer carries {tag, n}
   task automatic test_fairness;
      int cnt [N];
      int k;
      int j;
      do_reset();
      cnt[0] = 0;
      cnt[1] = 0;
      for (int step = 0; step < 10; step++) begin
         for (int i = 0; i < N; i++)
            set_req(i, Req_ready[i], 3'(i + 1), {8'(i + 1), 8'(cnt[i])});
         tick();
         for (int i = 0; i < N; i++)
            if (Req_valid[i]) cnt[i]++;
         if (step >= 1) begin
            k = step - 1;
            j = k % 2;
            exp_v = {1'b1, 3'(j + 1), 8'(j + 1), 8'(k / 2), 2'(1 << j), 2'(1 << j)};
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL fair_step%0d: got %h exp %h", step, obs, exp_v); end
         end
      end
      Req_valid = '0;
   endtask

   task automatic test_back_pressure;
      do_reset();
      set_req(0, 1'b1, RES_STATION_ADD1, 16'h0011);
      set_req(1, 1'b1, RES_STATION_ADD2, 16'h0022);
      tick();
      set_req(0, 1'b0, RES_STATION_ADD1, 16'h0000);
      set_req(1, 1'b1, RES_STATION_ADD2, 16'h0099);
      exp_v = {1'b0, 3'd0, 16'hFFF0, 2'b00, 2'b00};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL bp_accept: got %h exp %h", obs, exp_v); end
      tick();
      exp_v = {1'b1, 3'd1, 16'h0011, 2'b01, 2'b01};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL bp_slot0: got %h exp %h", obs, exp_v); end
      tick();
      exp_v = {1'b1, 3'd2, 16'h0022, 2'b10, 2'b11};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL bp_held_data: got %h exp %h", obs, exp_v); end
      Req_valid = '0;
      tick();
      exp_v = {1'b0, 3'd0, 16'hFFF0, 2'b00, 2'b11};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL bp_once: got %h exp %h", obs, exp_v); end
   endtask

   task automatic test_tag0;
      do_reset();
      set_req(0, 1'b1, FREE_REGISTER, 16'h0077);
      tick();
      Req_valid = '0;
      checks++;
      if (Err_tag0 !== 1'b1) begin errors++; $display("FAIL tag0_err_set: got %b exp 1", Err_tag0); end
      exp_v = {1'b0, 3'd0, 16'hFFF0, 2'b00, 2'b11};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL tag0_not_stored: got %h exp %h", obs, exp_v); end
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL tag0_no_bcast: got %h exp %h", obs, exp_v); end
      set_req(1, 1'b1, RES_STATION_ADD2, 16'h0033);
      tick();
      Req_valid = '0;
      tick();
      exp_v = {1'b1, 3'd2, 16'h0033, 2'b10, 2'b11};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL tag0_traffic: got %h exp %h", obs, exp_v); end
      checks++;
      if (Err_tag0 !== 1'b1) begin errors++; $display("FAIL tag0_sticky: got %b exp 1", Err_tag0); end
      do_reset();
      checks++;
      if (Err_tag0 !== 1'b0) begin errors++; $display("FAIL tag0_cleared: got %b exp 0", Err_tag0); end
   endtask

   // rr_ptr is left at 1 with both slots full, so a missed pointer reset shows as slot 1 winning first
   task automatic test_reset_midop;
      do_reset();
      set_req(0, 1'b1, RES_STATION_ADD1, 16'h0041);
      tick();
      Req_valid = '0;
      tick();
      exp_v = {1'b1, 3'd1, 16'h0041, 2'b01, 2'b11};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rst_pre_bcast: got %h exp %h", obs, exp_v); end
      set_req(0, 1'b1, RES_STATION_ADD1, 16'h0051);
      set_req(1, 1'b1, RES_STATION_ADD2, 16'h0052);
      tick();
      Req_valid = '0;
      exp_v = {1'b0, 3'd0, 16'hFFF0, 2'b00, 2'b00};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rst_both_full: got %h exp %h", obs, exp_v); end
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      exp_v = {1'b0, 3'd0, 16'hFFF0, 2'b00, 2'b11};
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL rst_idle_c%0d: got %h exp %h", c, obs, exp_v); end
         tick();
      end
      set_req(0, 1'b1, RES_STATION_ADD1, 16'h0061);
      set_req(1, 1'b1, RES_STATION_ADD2, 16'h0062);
      tick();
      Req_valid = '0;
      tick();
      exp_v = {1'b1, 3'd1, 16'h0061, 2'b01, 2'b01};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rst_ptr_zero: got %h exp %h", obs, exp_v); end
      tick();
      exp_v = {1'b1, 3'd2, 16'h0062, 2'b10, 2'b11};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rst_post_second: got %h exp %h", obs, exp_v); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_collision();
      test_fairness();
      test_back_pressure();
      test_tag0();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
